// File: rtl/data_mem_responder.sv
// Load/store responder for the MEM stage: one request in flight, RV32I funct3 byte-lane
// rules, programmable wait states, single-cycle response pulse with error flag.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_wait_cnt;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_misal, w_illegal, w_oor, w_err;
  logic [IDXW-1:0]       w_idx;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wword;
  logic [DATA_WIDTH-1:0] w_rword;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic                  w_commit;

  assign req_ready_o  = (r_state == S_IDLE);
  assign w_accept     = req_valid_i && req_ready_o;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid_i) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (r_wait_cnt == 4'(WAIT_CYCLES)) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Wait counter counts 1..WAIT_CYCLES while in WAIT, then parks at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= (WAIT_CYCLES > 0) ? 4'd1 : 4'd0;
    end else if (r_state == S_WAIT) begin
      if (r_wait_cnt == 4'(WAIT_CYCLES)) r_wait_cnt <= '0;
      else                                r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_write  <= req_write_i;
      r_funct3 <= req_funct3_i;
      r_addr   <= req_addr_i;
      r_wdata  <= req_wdata_i;
    end
  end

  always_comb begin
    w_misal   = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    w_illegal = r_write ? (r_funct3 >= 3'd3)
                        : ((r_funct3 == 3'd3) || (r_funct3 == 3'd6) || (r_funct3 == 3'd7));
    w_oor     = {2'b00, r_addr[DATA_WIDTH-1:2]} >= 32'(DEPTH);
    w_err     = w_misal || w_illegal || w_oor;
  end

  assign w_idx = r_addr[IDXW+1:2];

  // Store lanes: replicate the narrow datum and let the byte enables pick the lane.
  always_comb begin
    w_be    = 4'b0000;
    w_wword = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wword = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{r_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_commit = (r_state == S_ACCESS) && r_write && !w_err;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_idx];

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = w_rword[7:0];
      2'b01:   w_byte = w_rword[15:8];
      2'b10:   w_byte = w_rword[23:16];
      default: w_byte = w_rword[31:24];
    endcase
    w_half = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
  end

  always_comb begin
    w_load = '0;
    case (r_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd2:    w_load = w_rword;
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = '0;
    endcase
  end

  // Response data and error hold until the next ACCESS edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= (r_state == S_ACCESS);
      if (r_state == S_ACCESS) begin
        r_resp_rdata <= (w_err || r_write) ? '0 : w_load;
        r_resp_err   <= w_err;
      end
    end
  end

endmodule
